// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// ifu_fetch: instruction-fetch initiator. Issues one-word requests to the
// instruction SRAM, tags each returned word with its PC, buffers it in a
// 2-entry skid FIFO and presents the head to decode with valid/ready.
// A branch redirects the fetch stream in the same cycle, flushes the FIFO
// and kills the response that is still on its way back.
module ifu_fetch #(
  parameter int          AW       = 16,
  parameter logic [AW-1:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rstn,
  output logic [AW-1:0] ins_a,
  output logic          ins_e,
  input  logic [31:0]   ins,
  input  logic          branch,
  input  logic [AW-1:0] branch_pc,
  input  logic          ifu_rdy,
  output logic          ifu_vld,
  output logic [31:0]   ifu_pc,
  output logic [31:0]   ifu_ins
);

  localparam logic [AW-1:0] PC_STEP = AW'(4);

  // Fetch pointer and the single outstanding request
  logic [AW-1:0] pc;
  logic          req_vld;
  logic [AW-1:0] req_pc;

  // Skid FIFO: two slots addressed by a 1-bit read pointer plus an occupancy count
  logic [AW-1:0] buf_pc  [2];
  logic [31:0]   buf_ins [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    cnt;

  logic          raw_pop;
  logic          pop;
  logic          push;
  logic [2:0]    occ_after;
  logic [AW-1:0] fetch_addr;

  // Handshake qualifiers: a branch overrides both the pop and the response push
  assign raw_pop = ifu_vld & ifu_rdy;
  assign pop     = raw_pop & ~branch;
  assign push    = req_vld & ~branch;

  // Slots that would still be claimed after this edge; a new request needs one free
  assign occ_after = 3'(cnt) + 3'(req_vld) - 3'(raw_pop);

  // Same-cycle redirect bypass onto the SRAM address
  assign fetch_addr = branch ? {branch_pc[AW-1:2], 2'b00} : pc;

  // Request issue: a branch always issues because the flush frees both slots
  always_comb begin
    ins_a = fetch_addr;
    ins_e = rstn & (branch | (occ_after < 3'd2));
  end

  // Tail slot sits cnt entries past the head (wraps onto the head when full)
  assign wr_ptr = rd_ptr ^ cnt[0];

  // Decode-facing view of the FIFO head, PC zero-extended to 32 bits
  always_comb begin
    ifu_vld = (cnt != 2'd0);
    ifu_pc  = 32'(buf_pc[rd_ptr]);
    ifu_ins = buf_ins[rd_ptr];
  end

  // Fetch pointer and outstanding-request tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= RESET_PC;
      req_vld <= 1'b0;
      req_pc  <= '0;
    end else begin
      req_vld <= ins_e;
      if (ins_e) begin
        req_pc <= fetch_addr;
        pc     <= fetch_addr + PC_STEP;
      end
    end
  end

  // FIFO occupancy and head pointer; a branch empties the buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
    end else if (branch) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
    end else begin
      cnt    <= cnt + 2'(push) - 2'(pop);
      rd_ptr <= rd_ptr ^ pop;
    end
  end

  // FIFO storage: returned word is written at the tail together with its PC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]  <= '0;
        buf_ins[i] <= '0;
      end
    end else if (push) begin
      buf_pc[wr_ptr]  <= req_pc;
      buf_ins[wr_ptr] <= ins;
    end
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch initiator for the core: drives the instruction SRAM port (ins_a/ins_e) and captures returned words (ins).
- Tags each returned word with its PC and buffers it in a 2-entry skid FIFO.
- Presents the buffer head to decode with a valid/ready handshake.
- Handles branch redirects by flushing the buffer and discarding in-flight fetches.

Parameters:
- RESET_PC, 16'h0000, byte address of first fetch after reset (word-aligned)
- AW, 16, instruction byte-address width

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- ins_a  out  AW  fetch byte address; bits [1:0] always 0
- ins_e  out  1  fetch request enable
- ins  in  32  fetched word, valid in the cycle after the request cycle
- branch  in  1  redirect pulse from execute
- branch_pc  in  AW  redirect target; bits [1:0] ignored (treated as 0)
- ifu_rdy  in  1  decode accepts head entry this cycle
- ifu_vld  out  1  head entry valid
- ifu_pc  out  32  PC of head entry, zero-extended from AW
- ifu_ins  out  32  instruction word of head entry

Behaviour:
- Clock and reset:
  - Single clock; reset is asynchronous and active-low.
  - Reset values: pc=RESET_PC, FIFO count=0, req_vld=0, ifu_vld=0, ifu_pc=0, ifu_ins=0, ins_e=0.
- Memory protocol:
  - A request issued in cycle N (ins_e=1, ins_a=A) is captured by the SRAM at the edge ending N.
  - The word at A is stable on ins throughout cycle N+1 and is sampled at the edge ending N+1.
  - ins is don't-care in cycles with no outstanding request.
- Request tracking:
  - req_vld/req_pc registers record a request issued in the previous cycle. At most one request is outstanding.
- Issue rule:
  - ins_e = !branch_flush_block && (cnt + req_vld - pop) < 2, where pop = ifu_vld & ifu_rdy.
  - This guarantees every returning word has a FIFO slot; no response is ever dropped except by branch kill.
  - ins_a = branch ? {branch_pc[AW-1:2],2'b00} : pc (same-cycle redirect bypass).
  - In the branch cycle, ins_e=1 unconditionally, since the flush frees both slots.
- PC update:
  - On issue, pc <= ins_a + 4, wrapping modulo 2^AW (0xFFFC -> 0x0000).
  - With no issue and no branch, pc holds.
- Response:
  - If req_vld && !branch at an edge, {req_pc, ins} is pushed to the FIFO tail.
  - Fetch-to-ifu_vld latency is 2 cycles: request in cycle N, entry visible in cycle N+2.
- FIFO:
  - 2 entries, registered.
  - ifu_vld = cnt != 0; ifu_pc/ifu_ins come from the head.
  - Push and pop in the same cycle are legal at any count.
  - Outputs hold stable while ifu_vld && !ifu_rdy.
- Branch:
  - In the branch cycle, ifu_vld may still be high; decode must ignore it (valid qualified by !branch).
  - A pop in the branch cycle has no effect.
  - At the edge, FIFO cnt <= 0 and the outstanding response is killed (req_vld's data is not pushed).
  - The new request to branch_pc becomes the only outstanding request; its entry appears 2 cycles after branch.
- Simultaneous events:
  - Branch wins over push, pop, and issue stall.
  - Back-to-back branch pulses: each overrides the previous; only the last target's fetch is kept.
- Reset mid-operation:
  - Everything clears immediately (async), including the outstanding request.
  - The first request after rstn rises goes to RESET_PC in the first cycle with rstn=1.
- Steady state:
  - With ifu_rdy=1 continuously, one instruction per cycle and ins_e stays high.

Test Plan:
1. RESET_PC=0, ifu_rdy=1, SRAM words 0x00000013+i: ins_e=1 with ins_a=0,4,8 in cycles 0,1,2 after rstn rises -> ifu_vld from cycle 2 with (ifu_pc, ifu_ins)=(0,0x13),(4,0x14),(8,0x15), one per cycle, no bubbles.
2. Backpressure: ifu_rdy=0 for cycles 4-7 -> cnt reaches 2, ins_e deasserts once cnt+req_vld=2, ifu_pc frozen at head; on ifu_rdy=1, PCs continue contiguous with no gap, duplicate, or loss.
3. Branch with branch_pc=0x0101 while cnt=2 and a request is outstanding -> in the branch cycle ins_a=0x0100, ins_e=1; 2 cycles later ifu_vld=1, ifu_pc=0x100; no stale PC appears afterwards.
4. Branch in consecutive cycles to 0x40 then 0x80 -> the first delivered entry after the branches has ifu_pc=0x80; 0x40 never appears.
5. RESET_PC=0xFFF8 -> delivered PCs are 0xFFF8, 0xFFFC, 0x0000, 0x0004 in order.
6. Assert rstn=0 mid-stream with cnt=1 and a request outstanding -> ifu_vld=0 and ins_e=0 immediately; after release, the first request is to RESET_PC and the first entry delivered is RESET_PC's word.
